// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared sizing helpers for the synchronous FIFO family
package sync_fifo_pkg;
  localparam int MIN_DEPTH = 2;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  // n entries, wraps after n-1 so non-power-of-two sizes work
  function automatic int ptr_inc(input int p, input int n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_stream_if.sv
// sync_fifo_stream_if: valid/ready stream bundle
interface sync_fifo_stream_if #(parameter int W = 32);
  logic [W-1:0] data;
  logic valid;
  logic ready;
  modport master (output data, valid, input ready);
  modport slave (input data, valid, output ready);
endinterface

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: W x N storage, registered write, asynchronous read
module sync_fifo_ram #(
  parameter int W = 32,
  parameter int N = 15,
  parameter int AW = 4
) (
  input  logic clk,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [N];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_stream.sv
// sync_fifo_stream: FWFT stream FIFO of any DEPTH >= 2 with programmable flags and flush.
// Define SYNC_FIFO_STREAM_HWM_EN to enable the high-water-mark register.
module sync_fifo_stream
  import sync_fifo_pkg::*;
#(
  parameter int W = 32,
  parameter int DEPTH = 16,
  localparam int LW = clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  sync_fifo_stream_if.slave in_st,
  sync_fifo_stream_if.master out_st,
  input  logic [LW-1:0] af_thr,
  input  logic [LW-1:0] ae_thr,
  output logic [LW-1:0] level,
  output logic full,
  output logic empty,
  output logic afull,
  output logic aempty,
  output logic [LW-1:0] hwm
);
  localparam int PW = clog2(DEPTH - 1) > 0 ? clog2(DEPTH - 1) : 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [W-1:0] ram_rdata;
  logic [LW-1:0] lvl_nxt;
  logic clr, push, pop, load, ram_empty, ram_rd, bypass, ram_wr;
  if (DEPTH < MIN_DEPTH) begin : g_depth_chk
    $error("sync_fifo_stream: DEPTH must be >= %0d", MIN_DEPTH);
  end
  assign clr = ~rst_n | flush;
  assign in_st.ready = rst_n & ~full & ~flush;
  assign push = in_st.valid & in_st.ready;
  assign pop = out_st.valid & out_st.ready;
  // the output register is always filled first, so the RAM holds level minus the head entry
  assign ram_empty = level == LW'(out_st.valid);
  assign load = ~out_st.valid | pop;
  assign ram_rd = load & ~ram_empty;
  assign bypass = load & ram_empty & push;
  assign ram_wr = push & ~bypass;
  assign lvl_nxt = clr ? '0 : level + LW'(push) - LW'(pop);
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign afull = (af_thr > LW'(DEPTH)) | (level >= LW'(DEPTH) - af_thr);
  assign aempty = level <= ae_thr;
  always_ff @(posedge clk) begin
    level <= lvl_nxt;
    rd_ptr <= clr ? '0 : ram_rd ? PW'(ptr_inc(32'(rd_ptr), DEPTH - 1)) : rd_ptr;
    wr_ptr <= clr ? '0 : ram_wr ? PW'(ptr_inc(32'(wr_ptr), DEPTH - 1)) : wr_ptr;
    out_st.valid <= clr ? 1'b0 : load ? (~ram_empty | push) : out_st.valid;
    out_st.data <= !rst_n ? '0 : flush ? out_st.data : ram_rd ? ram_rdata : bypass ? in_st.data : out_st.data;
  end
  sync_fifo_ram #(.W(W), .N(DEPTH - 1), .AW(PW)) u_ram (
    .clk(clk),
    .we(ram_wr),
    .waddr(wr_ptr),
    .wdata(in_st.data),
    .raddr(rd_ptr),
    .rdata(ram_rdata)
  );
`ifdef SYNC_FIFO_STREAM_HWM_EN
  always_ff @(posedge clk) hwm <= clr ? '0 : (lvl_nxt > hwm) ? lvl_nxt : hwm;
`else
  assign hwm = '0;
`endif
`ifndef SYNTHESIS
  // producer must hold valid and data steady while stalled
  logic stall_q;
  logic [W-1:0] data_q;
  always_ff @(posedge clk) begin
    stall_q <= rst_n & ~flush & in_st.valid & ~in_st.ready;
    data_q <= in_st.data;
    if (stall_q && rst_n && !flush && !in_st.valid) $error("sync_fifo_stream: in_valid dropped while stalled");
    if (stall_q && rst_n && !flush && in_st.valid && in_st.data != data_q) $error("sync_fifo_stream: in_data changed while stalled");
  end
`endif
endmodule
